// File: rtl/bits_unpacker_pkg.sv
// Shared types and field accessors for the 10-byte little-endian record unpacker.
package bits_unpacker_pkg;

  localparam int unsigned RECORD_BYTES = 10;
  localparam int unsigned REC_W        = RECORD_BYTES * 8;
  localparam logic [3:0]  LAST_IDX     = 4'(RECORD_BYTES - 1);

  typedef struct packed {
    logic [31:0] first;
    logic [31:0] second;
  } pair_t;

  typedef struct packed {
    logic       a;
    logic [1:0] b;
    logic [3:0] c;
    logic [7:0] d;
  } abcd_t;

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    HOLD
  } state_t;

  // Byte n of the record lives at bits [8n+7:8n].
  typedef logic [REC_W-1:0] rec_t;

  function automatic pair_t get_pair(input rec_t r);
    pair_t p;
    p.first  = r[31:0];
    p.second = r[63:32];
    return p;
  endfunction

  function automatic abcd_t get_abcd(input rec_t r);
    abcd_t f;
    f.d = r[71:64];
    f.c = r[75:72];
    f.b = r[77:76];
    f.a = r[78];
    return f;
  endfunction

  function automatic logic get_reserved(input rec_t r);
    return r[REC_W-1];
  endfunction

endpackage

// File: rtl/bits_unpacker.sv
// Collects a byte stream into a fixed 10-byte record, flags framing errors and
// holds the decoded fields until the consumer takes them.
module bits_unpacker
  import bits_unpacker_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_pair,
  output logic [14:0]          out_abcd,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t     state;
  logic [3:0] idx;
  rec_t       rec;
  logic       err_flag;

  logic       accept;
  rec_t       rec_wr;
  rec_t       term_rec;
  logic       term_err;

  always_comb begin
    accept = in_valid && (state != HOLD);
    rec_wr = rec;
    for (int unsigned i = 0; i < RECORD_BYTES; i++) begin
      if (idx == 4'(i)) rec_wr[i*8 +: 8] = in_data;
    end
    // In DRAIN the incoming byte is surplus, so the stored bytes 0-9 are final.
    term_rec = (state == DRAIN) ? rec : rec_wr;
    term_err = err_flag || (state == DRAIN) || (idx != LAST_IDX) ||
               get_reserved(term_rec);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= COLLECT;
      idx       <= '0;
      rec       <= '0;
      err_flag  <= 1'b0;
      err_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_pair  <= '0;
      out_abcd  <= '0;
    end else begin
      case (state)
        COLLECT, DRAIN: begin
          if (accept) begin
            if (in_last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_pair  <= get_pair(term_rec);
              out_abcd  <= get_abcd(term_rec);
              out_err   <= term_err;
            end else if (state == COLLECT) begin
              rec <= rec_wr;
              if (idx == LAST_IDX) begin
                state    <= DRAIN;
                err_flag <= 1'b1;
              end else begin
                idx <= idx + 4'd1;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= COLLECT;
            idx       <= '0;
            rec       <= '0;
            err_flag  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_pair  <= '0;
            out_abcd  <= '0;
            if (out_err && !(&err_count)) err_count <= err_count + 1'b1;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bits_unpacker.sv
// Randomized bench for bits_unpacker: a record-level model predicts handshakes,
// decoded fields and the saturating error counter for two counter widths.
module tb_bits_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, in_valid, in_last, out_ready;
  logic [7:0]  in_data;

  logic        in_ready, out_valid, out_err;
  logic [63:0] out_pair;
  logic [14:0] out_abcd;
  logic [7:0]  err_count;

  logic        in_ready2, out_valid2, out_err2;
  logic [63:0] out_pair2;
  logic [14:0] out_abcd2;
  logic [1:0]  err_count2;

  bits_unpacker dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_pair(out_pair), .out_abcd(out_abcd),
    .out_err(out_err), .err_count(err_count)
  );

  bits_unpacker #(.ERR_CNT_W(2)) dut_w2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_pair(out_pair2), .out_abcd(out_abcd2),
    .out_err(out_err2), .err_count(err_count2)
  );

  typedef struct packed {
    logic [63:0] pair;
    logic [14:0] abcd;
    logic        err;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;

  // Monitor-owned model state
  logic [7:0] cur [$];
  exp_t       exp_q [$];
  int         cnt8 = 0;
  int         cnt2 = 0;
  int         delivered = 0;
  logic       final_done = 1'b0;

  // Driver-owned state
  logic       rand_ready;
  logic       done;
  int         drv_timeouts;
  int         exp_deliv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Record rules: bytes 0-9 little-endian, missing bytes zero, error when the
  // length is not 10 or the reserved bit of byte 9 is set.
  function automatic exp_t expect_rec(input logic [7:0] q[$]);
    logic [7:0] b [10];
    exp_t e;
    for (int i = 0; i < 10; i++) b[i] = (i < q.size()) ? q[i] : 8'h00;
    e.pair = {b[3], b[2], b[1], b[0], b[7], b[6], b[5], b[4]};
    e.abcd = {b[9][6:0], b[8]};
    e.err  = (q.size() != 10) || b[9][7];
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    logic acc;
    exp_t e;
    if (!resetn) begin
      cur.delete();
      exp_q.delete();
      cnt8 = 0;
      cnt2 = 0;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_err", 64'(out_err), 64'(0));
      chk("rst_out_pair", out_pair, 64'(0));
      chk("rst_out_abcd", 64'(out_abcd), 64'(0));
      chk("rst_err_count", 64'(err_count), 64'(0));
      chk("rst_err_count_w2", 64'(err_count2), 64'(0));
      chk("rst_out_valid_w2", 64'(out_valid2), 64'(0));
    end else begin
      acc = in_valid && (exp_q.size() == 0);
      chk("err_count", 64'(err_count), 64'(cnt8));
      chk("err_count_w2", 64'(err_count2), 64'(cnt2));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
      chk("in_ready_w2", 64'(in_ready2), 64'(exp_q.size() == 0));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("out_valid_w2", 64'(out_valid2), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("out_pair", out_pair, e.pair);
        chk("out_abcd", 64'(out_abcd), 64'(e.abcd));
        chk("out_err", 64'(out_err), 64'(e.err));
        chk("out_pair_w2", out_pair2, e.pair);
        chk("out_abcd_w2", 64'(out_abcd2), 64'(e.abcd));
        chk("out_err_w2", 64'(out_err2), 64'(e.err));
        if (out_ready) begin
          void'(exp_q.pop_front());
          delivered++;
          if (e.err) begin
            cnt8 = (cnt8 == 255) ? 255 : cnt8 + 1;
            cnt2 = (cnt2 == 3) ? 3 : cnt2 + 1;
          end
        end
      end
      if (acc) begin
        cur.push_back(in_data);
        if (in_last) begin
          exp_q.push_back(expect_rec(cur));
          cur.delete();
        end
      end
    end
    chk("driver_timeouts", 64'(drv_timeouts), 64'(0));
    if (done && !final_done) begin
      chk("deliveries", 64'(delivered), 64'(exp_deliv));
      final_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_accept();
    int n = 0;
    logic acc;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) drv_timeouts++;
  endtask

  task automatic send_record(input logic [7:0] q[$], input int unsigned gap_max,
                             input logic with_last);
    for (int i = 0; i < q.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = q[i];
      in_last  = with_last && (i == q.size() - 1);
      wait_accept();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) drv_timeouts++;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    resetn   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : driver
    logic [7:0] q [$];
    logic [7:0] good [$];
    int unsigned len;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; rand_ready = 1'b0; done = 1'b0;
    drv_timeouts = 0; exp_deliv = 0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    good = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hCA, 8'h7B};
    send_record(good, 0, 1'b1); exp_deliv++; drain();

    // Consumer stalls for 5 cycles
    out_ready = 1'b0;
    send_record(good, 0, 1'b1); exp_deliv++;
    repeat (5) tick();
    out_ready = 1'b1;
    drain();

    q = {8'h11, 8'h22, 8'h33};
    send_record(q, 1, 1'b1); exp_deliv++; drain();

    q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'hEE, 8'hFF};
    send_record(q, 1, 1'b1); exp_deliv++; drain();

    q = {8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hCA, 8'hFB};
    send_record(q, 0, 1'b1); exp_deliv++; drain();

    // Reset mid-record, then a clean record
    q = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_record(q, 0, 1'b0);
    pulse_reset();
    send_record(good, 0, 1'b1); exp_deliv++; drain();

    // Reset while a record is held
    out_ready = 1'b0;
    send_record(good, 0, 1'b1);
    tick();
    pulse_reset();
    out_ready = 1'b1;
    tick();

    // Five bad records walk the 2-bit counter into saturation
    for (int r = 0; r < 5; r++) begin
      q = {8'($urandom), 8'($urandom)};
      send_record(q, 1, 1'b1); exp_deliv++; drain();
    end

    rand_ready = 1'b1;
    for (int r = 0; r < 80; r++) begin
      len = ($urandom_range(0, 1) != 0) ? 10 : $urandom_range(1, 14);
      q.delete();
      for (int unsigned k = 0; k < len; k++) q.push_back(8'($urandom));
      send_record(q, 2, 1'b1); exp_deliv++;
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    done = 1'b1;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bits_unpacker.md
BITS_UNPACKER -- requirements
Module: bits_unpacker

Interface
REQ-001 Parameter: ERR_CNT_W, default 8, width of the saturating framing-error counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  byte beat valid.
REQ-005 in_ready  output  1  byte beat accepted when in_valid && in_ready.
REQ-006 in_data  input  8  byte payload.
REQ-007 in_last  input  1  marks final byte of a record.
REQ-008 out_valid  output  1  assembled record valid.
REQ-009 out_ready  input  1  consumer takes record when out_valid && out_ready.
REQ-010 out_pair  output  64  pair_t {first[31:0], second[31:0]}.
REQ-011 out_abcd  output  15  abcd_t {a[14], b[13:12], c[11:8], d[7:0]}.
REQ-012 out_err  output  1  record is malformed; qualified by out_valid.
REQ-013 err_count  output  ERR_CNT_W  count of records emitted with out_err=1, saturating.

Function
REQ-014 The record SHALL be exactly 10 bytes, little-endian: bytes 0-3 = first[7:0]..first[31:24], bytes 4-7 = second[7:0]..second[31:24], byte 8 = abcd[7:0], byte 9 = {reserved bit 7, abcd[14:8]}.
REQ-015 The FSM SHALL have three states: COLLECT, DRAIN, HOLD.
REQ-016 COLLECT: in_ready=1, out_valid=0; each accepted byte SHALL be written to the slot selected by a 4-bit byte index, and the index SHALL increment.
REQ-017 Accepting byte 9 with in_last=1 SHALL move to HOLD; out_err SHALL be 1 iff byte 9 bit 7 is set.
REQ-018 Accepting in_last=1 at index 0-8 (short record) SHALL move to HOLD with out_err=1; unwritten slots SHALL read zero.
REQ-019 Accepting byte 9 with in_last=0 (long record) SHALL move to DRAIN with the error flag set.
REQ-020 DRAIN: in_ready=1, out_valid=0; accepted bytes SHALL be discarded; the accepted byte with in_last=1 SHALL move to HOLD (out_err=1, fields from bytes 0-9).
REQ-021 HOLD: in_ready=0, out_valid=1; out_pair/out_abcd/out_err SHALL stay stable until out_ready=1.
REQ-022 In HOLD with out_ready=1, the FSM SHALL move to COLLECT next cycle, clearing the index, the assembly buffer and the error flag.
REQ-023 out_valid SHALL rise in the cycle after the terminating byte is accepted (latency 1); back-to-back records SHALL cost one idle input cycle per HOLD handshake, i.e. in_ready is low for at least one cycle.
REQ-024 err_count SHALL increment by 1 on each HOLD handshake with out_err=1 and SHALL hold at all-ones.
REQ-025 in_valid=0 SHALL leave all state unchanged; in_data and in_last SHALL be ignored when in_valid=0.

Reset
REQ-026 resetn low SHALL immediately force state=COLLECT, index=0, buffer=0, error flag=0, err_count=0, out_valid=0, out_err=0, out_pair=0, out_abcd=0.
REQ-027 Reset asserted mid-record or in HOLD SHALL discard the partial or pending record; no output SHALL be produced for it.
REQ-028 After resetn deasserts, the first accepted byte SHALL be taken as byte 0.

Structure
REQ-029 The shared package SHALL hold pair_t, abcd_t, the state enum and the constant RECORD_BYTES=10.
REQ-030 The block SHALL be a single module with no sub-module; field extraction SHALL be done through package accessor functions.

Verification
REQ-031 Stream 78 56 34 12 EF BE AD DE CA 7B, last on byte 9 -> first=0x12345678, second=0xDEADBEEF, abcd=0x7BCA (a=1, b=3, c=11, d=202), out_err=0.
REQ-032 Same stream with out_ready held low 5 cycles -> out_valid and fields stable for those 5 cycles, in_ready=0, one record delivered.
REQ-033 Short record 11 22 33 with last on byte 2 -> first=0x00332211, second=0, abcd=0, out_err=1, err_count=1.
REQ-034 12-byte record, last on byte 11 -> bytes 10-11 dropped, fields from bytes 0-9, out_err=1; byte 9=0xFB -> out_err=1 from the reserved bit alone.
REQ-035 resetn pulsed low after byte 5 of a record, then a clean record sent -> only the clean record emitted, err_count=0.
REQ-036 With ERR_CNT_W=2, five bad records -> err_count reads 1, 2, 3, 3, 3.
